// File: rtl/bus_pkg.sv
// Shared types and helpers for the strobe-bus master and its cycle counter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    GAP    = 2'b10
  } bus_state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Wide enough to hold ACCESS_CYC-1 and IDLE_CYC-1, never narrower than 1 bit.
  function automatic int cnt_width(input int acc_cyc, input int idle_cyc);
    int m;
    m = (acc_cyc > idle_cyc) ? acc_cyc : idle_cyc;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/bus_cycle_cnt.sv
// Loadable down-counter that saturates at zero; shared by the access and gap phases.
// Load wins over decrement; zero reflects the registered count, no backpressure.
module bus_cycle_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bus_master_ctrl.sv
// Single-transaction master for the active-low cs/wr/rd strobe bus, reads and writes.
// Bus active 1 cycle after handshake for ACCESS_CYC cycles; req_ready low until access and gap finish.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ACCESS_CYC = 3,
  parameter int IDLE_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int            CW      = cnt_width(ACCESS_CYC, IDLE_CYC);
  localparam logic [CW-1:0] ACC_LD  = CW'(ACCESS_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);
  localparam bit            HAS_GAP = (IDLE_CYC > 0);

  if (ACCESS_CYC < 1) begin : g_bad_access_cyc
    $error("bus_master_ctrl: ACCESS_CYC must be >= 1");
  end
  if (IDLE_CYC < 0) begin : g_bad_idle_cyc
    $error("bus_master_ctrl: IDLE_CYC must be >= 0");
  end

  bus_state_t    state;
  logic          accept;
  logic          access_done;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = req_valid & req_ready;
  assign access_done = (state == ACCESS) & cnt_zero;
  assign cnt_load    = accept | (access_done & HAS_GAP);
  assign cnt_val     = accept ? ACC_LD : GAP_LD;

  bus_cycle_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cs_n      <= 1'b1;
      wr_n      <= 1'b1;
      rd_n      <= 1'b1;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ACCESS;
            cs_n      <= 1'b0;
            wr_n      <= ~req_wr;
            rd_n      <= req_wr;
            bus_addr  <= req_addr;
            bus_wdata <= (req_wr == OP_WR) ? req_wdata : '0;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            // rd_n still low here identifies the finishing access as a read
            if (!rd_n) rsp_rdata <= bus_rdata;
            rsp_valid <= 1'b1;
            cs_n      <= 1'b1;
            wr_n      <= 1'b1;
            rd_n      <= 1'b1;
            bus_addr  <= '0;
            bus_wdata <= '0;
            state     <= HAS_GAP ? GAP : IDLE;
          end
        end
        GAP: begin
          if (cnt_zero) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_master_ctrl.md
Name: bus_master_ctrl

Overview:
Synthesizable, parametrised bus-write/read master for the active-low cs/wr strobe bus. It accepts single transactions from an internal requester over a valid/ready handshake and drives cs_n, wr_n, rd_n, address and write data for a programmable number of clock cycles. It adds read support with captured read data, a completion pulse, and a guaranteed inter-access idle gap. It sits between the core logic and the external peripheral bus.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
ACCESS_CYC, 3, cycles cs_n is held low per access; must be ≥1, checked at elaboration
IDLE_CYC, 1, extra cycles cs_n stays high after an access before the next request is accepted; must be ≥0

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  transaction address
req_wdata  in  DATA_W  write data; ignored for reads
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data from last completed read
busy  out  1  access or gap in progress
cs_n  out  1  chip select, active-low
wr_n  out  1  write strobe, active-low
rd_n  out  1  read strobe, active-low
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (rst_n = 0, async): state IDLE, counter 0. cs_n/wr_n/rd_n = 1. bus_addr, bus_wdata, rsp_rdata = 0. rsp_valid = 0, busy = 0.
- All bus outputs are registered. req_ready = (state == IDLE), combinational from state, so it is 1 immediately out of reset.
- States:
  - IDLE: accept a request when req_valid & req_ready at a rising edge, then go to ACCESS.
  - ACCESS: held for ACCESS_CYC cycles. Next state is GAP if IDLE_CYC > 0, else IDLE.
  - GAP: held for IDLE_CYC cycles, then IDLE.
- On the accept edge, registered outputs become:
  - cs_n = 0; wr_n = ~req_wr; rd_n = req_wr; bus_addr = req_addr.
  - bus_wdata = req_wdata for writes, 0 for reads.
- The signals are stable for exactly ACCESS_CYC cycles. The first bus cycle is the cycle after the handshake, giving 1-cycle request-to-bus latency.
- Down-counter: loaded with ACCESS_CYC-1 on accept and IDLE_CYC-1 on GAP entry; the state exits when the counter reaches 0.
- Last ACCESS edge:
  - For reads, capture bus_rdata into rsp_rdata.
  - Pulse rsp_valid high for the following single cycle, for reads and writes.
  - Return cs_n/wr_n/rd_n to 1 and bus_addr/bus_wdata to 0.
- rsp_rdata holds its value until the next read completes; writes do not change it.
- Minimum cs_n high time between back-to-back accesses is IDLE_CYC+1 cycles: the GAP cycles plus the IDLE accept cycle.
- busy = 1 in ACCESS and GAP.
- req_* inputs are sampled only at handshake. Changes during ACCESS or GAP are ignored. req_valid deasserted in IDLE produces no bus activity.
- wr_n and rd_n are never low simultaneously. Neither is low while cs_n is high.
- Reset mid-access or mid-gap aborts immediately (async): strobes go high, rsp_valid is not issued, rsp_rdata clears to 0.
- ACCESS_CYC = 1 is legal: a single-cycle strobe with rsp_valid on the next cycle.

Decomposition:
- Shared package bus_pkg holds:
  - state enum bus_state_t {IDLE, ACCESS, GAP};
  - op constants OP_RD = 1'b0, OP_WR = 1'b1;
  - a function computing the counter width, clog2(max(ACCESS_CYC, IDLE_CYC, 2)).
- One natural sub-module: bus_cycle_cnt, a loadable down-counter with load, load value and a zero flag, instantiated once and shared by ACCESS and GAP.

Test Plan:
- Defaults, clk 10 ns: reset, then write 32'h1100008a / 32'h11113000 → cs_n = wr_n = 0 for exactly 3 cycles (30 ns), bus_addr/bus_wdata stable, rd_n = 1, rsp_valid one pulse, then addr/data return to 0.
- Read addr 32'h00000010 with bus_rdata = 32'hDEADBEEF → rd_n low 3 cycles, wr_n = 1, bus_wdata = 0, rsp_rdata = 32'hDEADBEEF with rsp_valid; a following write leaves rsp_rdata unchanged.
- req_valid held high for 3 back-to-back writes, IDLE_CYC = 1 → cs_n high exactly 2 cycles between accesses, req_ready high only in IDLE, 3 rsp_valid pulses.
- ACCESS_CYC = 1, IDLE_CYC = 0 → 1-cycle strobes, cs_n high 1 cycle between back-to-back accesses, latency request→cs_n = 1 cycle.
- rst_n asserted in the 2nd ACCESS cycle of a read → cs_n/rd_n go high asynchronously, no rsp_valid, rsp_rdata = 0, req_ready = 1 after release.
- Change req_addr/req_wdata during ACCESS → bus_addr/bus_wdata unchanged until the access ends.
